// File: rtl/aes_ctr_engine_pkg.sv
// Shared widths and the counter-increment helper for the AES-CTR stage.
package aes_ctr_engine_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_KEY_W   = 256;

  // Increment only the low ctr_bits of a counter block. The low field wraps
  // to zero and never carries into the fixed upper nonce bits.
  function automatic logic [AES_BLOCK_W-1:0] ctr_inc(input logic [AES_BLOCK_W-1:0] c,
                                                     input int ctr_bits);
    logic [AES_BLOCK_W-1:0] mask;
    if (ctr_bits >= AES_BLOCK_W) mask = '1;
    else                         mask = (AES_BLOCK_W'(1) << ctr_bits) - AES_BLOCK_W'(1);
    return (c & ~mask) | ((c + AES_BLOCK_W'(1)) & mask);
  endfunction

endpackage

// File: rtl/aes_ctr_engine_keystream_fifo.sv
// Synchronous keystream buffer. Clear overrides push and pop in the same cycle.
module keystream_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage write; entries need no reset because count tracks validity.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; clear empties the buffer regardless of push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/aes_ctr_engine.sv
// AES-CTR stage: issues counter blocks to a cipher core, buffers keystream,
// and XORs it onto plaintext blocks. A key or counter change flushes state.
module aes_ctr_engine
  import aes_ctr_engine_pkg::*;
#(
  parameter int KS_DEPTH = 4,
  parameter int CTR_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AES_KEY_W-1:0]   key,
  input  logic [AES_BLOCK_W-1:0] ctr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_block,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_block,
  output logic                   fifo_empty,
  output logic [AES_KEY_W-1:0]   core_key,
  output logic                   core_valid,
  input  logic                   core_ready,
  output logic [AES_BLOCK_W-1:0] core_block,
  input  logic                   core_res_valid,
  input  logic [AES_BLOCK_W-1:0] core_res
);

  localparam int CW = $clog2(KS_DEPTH) + 1;

  logic [AES_KEY_W-1:0]   key_q;
  logic [AES_BLOCK_W-1:0] ctr_q;
  logic [AES_BLOCK_W-1:0] next_ctr;
  logic [AES_BLOCK_W-1:0] pend_blk;
  logic [CW-1:0]          outstanding, outstanding_n;
  logic [CW-1:0]          discard, discard_n;
  logic [CW-1:0]          ks_count;
  logic [CW:0]            credit_used;
  logic [AES_BLOCK_W-1:0] ks_head;
  logic                   active, pend, pend_stale, pend_stale_n;
  logic                   flush, can_issue, core_hs, accept;
  logic                   ks_push, ks_pop, ks_empty, ks_full;

  keystream_fifo #(.DEPTH(KS_DEPTH), .W(AES_BLOCK_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (ks_push),
    .pop   (ks_pop),
    .din   (core_res),
    .dout  (ks_head),
    .count (ks_count),
    .empty (ks_empty),
    .full  (ks_full)
  );

  assign flush       = (key != key_q) || (ctr != ctr_q);
  assign credit_used = (CW+1)'(ks_count) + (CW+1)'(outstanding);
  // active keeps the request port quiet during and right at reset release.
  assign can_issue   = active && !pend && !flush && (discard == '0) &&
                       (credit_used < (CW+1)'(KS_DEPTH));
  assign core_valid  = pend || can_issue;
  assign core_block  = pend ? pend_blk : next_ctr;
  assign core_key    = key_q;
  assign core_hs     = core_valid && core_ready;

  assign in_ready    = !ks_empty && (!out_valid || out_ready) && !flush;
  assign accept      = in_valid && in_ready;
  assign ks_push     = core_res_valid && (discard == '0) && !flush;
  assign ks_pop      = accept;
  assign fifo_empty  = !out_valid;

  // Credit and discard bookkeeping. On a flush every request still in the
  // core (including one handed over this cycle) becomes a result to drop.
  always_comb begin
    outstanding_n = outstanding + CW'(core_hs) - CW'(core_res_valid);
    discard_n     = discard;
    if (flush) discard_n = outstanding_n;
    else       discard_n = discard + CW'(core_hs && pend_stale)
                                   - CW'(core_res_valid && (discard != '0));
    // A request held across a flush still completes; remember it is stale.
    pend_stale_n  = core_valid && !core_ready && (flush || (pend && pend_stale));
  end

  // Control state: shadows, counter, credits, held request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active      <= 1'b0;
      key_q       <= '0;
      ctr_q       <= '0;
      next_ctr    <= '0;
      outstanding <= '0;
      discard     <= '0;
      pend        <= 1'b0;
      pend_stale  <= 1'b0;
    end else begin
      active      <= 1'b1;
      outstanding <= outstanding_n;
      discard     <= discard_n;
      pend        <= core_valid && !core_ready;
      pend_stale  <= pend_stale_n;
      if (flush) begin
        key_q    <= key;
        ctr_q    <= ctr;
        next_ctr <= ctr;
      end else if (core_hs && !(pend && pend_stale)) begin
        next_ctr <= ctr_inc(core_block, CTR_BITS);
      end
    end
  end

  // Held request block; only meaningful while pend is set.
  always_ff @(posedge clk) begin
    pend_blk <= core_block;
  end

  // Output register: one-cycle XOR stage with valid/ready hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_block <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_block <= in_block ^ ks_head;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                  !(ks_push && ks_full && !ks_pop));

endmodule

// File: tb/tb_aes_ctr_engine.sv
// Scoreboard bench for aes_ctr_engine with a fixed-latency mock cipher core.
module tb_aes_ctr_engine;

  localparam int KS_DEPTH = 4;
  localparam int CTR_BITS = 32;

  localparam logic [255:0] K1   = {128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF,
                                   128'h0F0E0D0C_0B0A0908_07060504_03020100};
  localparam logic [255:0] K2   = {128'h11111111_22222222_33333333_44444444,
                                   128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C};
  localparam logic [127:0] C1   = 128'h5;
  localparam logic [127:0] C3   = {96'hA5A5A5A5_A5A5A5A5_A5A5A5A5, 32'hFFFF_FFFE};
  localparam logic [127:0] C4   = 128'h0000_0000_0000_0000_0000_0000_0000_0040;
  localparam logic [127:0] C4N  = 128'h100;
  localparam logic [127:0] C5   = 128'h7777_0000_0000_0000_0000_0000_1000_0000;
  localparam logic [127:0] P1   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] EXP1 = 128'h0F1F2F3F_4F5F6F7F_8F9FAFBF_CFDFEFFA;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] key = '0;
  logic [127:0] ctr = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_block = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_block;
  logic         fifo_empty;
  logic [255:0] core_key;
  logic         core_valid;
  logic         core_ready = 1'b1;
  logic [127:0] core_block;
  logic         core_res_valid;
  logic [127:0] core_res;

  aes_ctr_engine #(.KS_DEPTH(KS_DEPTH), .CTR_BITS(CTR_BITS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .key            (key),
    .ctr            (ctr),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_block       (in_block),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_block      (out_block),
    .fifo_empty     (fifo_empty),
    .core_key       (core_key),
    .core_valid     (core_valid),
    .core_ready     (core_ready),
    .core_block     (core_block),
    .core_res_valid (core_res_valid),
    .core_res       (core_res)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [127:0] exp_q[$];
  logic [255:0] cur_key = '0;
  logic [127:0] cur_base = '0;
  int cur_idx = 0;
  bit rnd_ready = 1'b0;
  bit track = 1'b0;
  int cyc = 0;
  int hs_cnt = 0;
  int acc_cnt = 0;
  int max_diff = 0;
  int last_acc = 0;

  // Mock cipher core: three-cycle latency, result = block ^ key[127:0].
  logic v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [127:0] d0 = '0, d1 = '0, d2 = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0; v1 <= 1'b0; v2 <= 1'b0;
    end else begin
      v0 <= core_valid && core_ready;
      d0 <= core_block ^ core_key[127:0];
      v1 <= v0; d1 <= d0;
      v2 <= v1; d2 <= d1;
    end
  end
  assign core_res_valid = v2;
  assign core_res       = d2;

  always @(negedge clk) core_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;

  always @(posedge clk) begin
    cyc++;
    if (rst_n && core_valid && core_ready) hs_cnt++;
  end

  always @(negedge clk) begin
    #3;
    if (track && (hs_cnt - acc_cnt > max_diff)) max_diff = hs_cnt - acc_cnt;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Output monitor: pops the scoreboard whenever a result is consumed.
  always @(negedge clk) begin
    logic [127:0] e;
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL out_unexpected: got %h required no output", out_block);
      end else begin
        e = exp_q.pop_front();
        check("out_block", 256'(out_block), 256'(e));
      end
    end
  end

  function automatic logic [127:0] ks(input logic [127:0] base, input int idx,
                                      input logic [255:0] k);
    logic [31:0] lo;
    lo = base[31:0] + 32'(idx);
    return {base[127:32], lo} ^ k[127:0];
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_exp(input logic [127:0] p, input logic [127:0] e);
    bit done;
    bit hs;
    int n;
    done = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_block = p;
    while (!done) begin
      #1;
      hs = in_ready;
      @(posedge clk);
      if (hs) begin
        exp_q.push_back(e);
        acc_cnt++;
        last_acc = cyc;
        done = 1'b1;
      end else if (n++ > 300) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got no in_ready required accept");
        done = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [127:0] p);
    send_exp(p, p ^ ks(cur_base, cur_idx, cur_key));
    cur_idx++;
  endtask

  task automatic set_cfg(input logic [255:0] k, input logic [127:0] c);
    key = k; ctr = c;
    cur_key = k; cur_base = c; cur_idx = 0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 256'(exp_q.size()), 256'(0));
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_out_valid"},  256'(out_valid),  256'(0));
    check({tag, "_out_block"},  256'(out_block),  256'(0));
    check({tag, "_in_ready"},   256'(in_ready),   256'(0));
    check({tag, "_core_valid"}, 256'(core_valid), 256'(0));
    check({tag, "_core_block"}, 256'(core_block), 256'(0));
    check({tag, "_fifo_empty"}, 256'(fifo_empty), 256'(1));
  endtask

  task automatic single_block(input string tag);
    out_ready = 1'b0;
    check({tag, "_idle_empty"}, 256'(fifo_empty), 256'(1));
    send_exp(P1, EXP1);
    in_valid = 1'b0;
    #1;
    check({tag, "_busy_empty"}, 256'(fifo_empty), 256'(0));
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check({tag, "_done_empty"}, 256'(fifo_empty), 256'(1));
    @(negedge clk);
    drain({tag, "_drain"});
  endtask

  initial begin
    int first, n;
    key = K1;
    ctr = C1;
    #1;
    reset_checks("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_cfg(K1, C1);
    repeat (10) @(negedge clk);

    // T1: single block with fifo_empty busy indication.
    single_block("t1");

    // T2: eight blocks streamed, bounded credits, near-full rate.
    set_cfg(K2, C1);
    hs_cnt = 0; acc_cnt = 0; max_diff = 0; track = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    send(128'h1000);
    first = last_acc;
    for (int i = 1; i < 8; i++) send(128'h1000 + 128'(i));
    in_valid = 1'b0;
    track = 1'b0;
    check("t2_credit_cap", 256'(max_diff <= KS_DEPTH), 256'(1));
    check("t2_rate", 256'((last_acc - first) >= 7 && (last_acc - first) <= 10), 256'(1));
    drain("t2_drain");

    // T3: low counter field wraps, upper bits fixed; random core_ready.
    rnd_ready = 1'b1;
    set_cfg(K2, C3);
    repeat (10) @(negedge clk);
    send(128'hFFFF_0000_1111_2222_3333_4444_5555_6666);
    send(128'h0);
    send(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    in_valid = 1'b0;
    drain("t3_drain");

    // T4: counter change while two requests are in the core.
    rnd_ready = 1'b0;
    set_cfg(K2, C4);
    repeat (10) @(negedge clk);
    send(128'hAAAA);
    send(128'hBBBB);
    in_valid = 1'b0;
    n = 0;
    #1;
    while ((32'(v0) + 32'(v1) + 32'(v2)) != 2 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t4_two_in_core", 256'(32'(v0) + 32'(v1) + 32'(v2)), 256'(2));
    @(negedge clk);
    set_cfg(K2, C4N);
    send(128'hCCCC);
    send(128'hDDDD);
    in_valid = 1'b0;
    drain("t4_drain");

    // T5: consumer stalls for ten cycles with input pending.
    set_cfg(K1, C5);
    repeat (10) @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        send(128'h5001);
        send(128'h5002);
        send(128'h5003);
        in_valid = 1'b0;
      end
      begin
        logic [127:0] held;
        int w;
        w = 0;
        while (!out_valid && w < 20) begin
          @(negedge clk);
          #1;
          w++;
        end
        held = out_block;
        repeat (10) begin
          @(negedge clk);
          #1;
          check("t5_in_ready", 256'(in_ready), 256'(0));
          check("t5_hold", 256'(out_block), 256'(held));
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain("t5_drain");

    // T6: asynchronous reset mid-stream, then the single-block case again.
    rnd_ready = 1'b1;
    out_ready = 1'b0;
    set_cfg(K2, C3);
    repeat (8) @(negedge clk);
    send(128'h6666);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    reset_checks("t6");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rnd_ready = 1'b0;
    set_cfg(K1, C1);
    repeat (10) @(negedge clk);
    single_block("t6_t1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
